// File: rtl/risc_core_mc_if.sv
// Shared memory port of the multi-cycle core: one request/ready handshake
// carries both instruction fetches and LD/ST data accesses.
interface risc_core_mc_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [DW-1:0] D_in;
  logic          mem_rdy;
  logic          mem_req;
  logic          mw_en;
  logic [AW-1:0] Address;
  logic [DW-1:0] D_out;

  modport master (
    input  D_in, mem_rdy,
    output mem_req, mw_en, Address, D_out
  );

  modport slave (
    output D_in, mem_rdy,
    input  mem_req, mw_en, Address, D_out
  );
endinterface

// File: rtl/risc_core_mc.sv
// Multi-cycle RISC core: FETCH -> DECODE -> EXEC [-> MEM], eight DW-bit
// registers, N/Z/C flags, wait-state memory handshake and a terminal HALT.
module risc_core_mc #(
  parameter int             DW       = 16,
  parameter int             AW       = 16,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  risc_core_mc_if.master        bus,
  output logic [7:0]            status,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h8, OP_LD  = 4'h9, OP_ST  = 4'hA, OP_JMP = 4'hB,
                         OP_BZ  = 4'hC, OP_BN  = 4'hD, OP_BC  = 4'hE, OP_HLT = 4'hF;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] rf_q [8];
  logic [DW-1:0] rf_d [8];
  logic          n_q, n_d, z_q, z_d, c_q, c_d;

  logic [3:0]    op;
  logic [2:0]    rd, rs, rt;
  logic [DW:0]   alu_res;
  logic          halted_int;

  assign op = ir_q[15:12];
  assign rd = ir_q[11:9];
  assign rs = ir_q[8:6];
  assign rt = ir_q[5:3];

  // Result in [DW-1:0], carry/borrow/shifted-out bit in [DW].
  function automatic logic [DW:0] alu(input logic [3:0] f,
                                      input logic [DW-1:0] x,
                                      input logic [DW-1:0] y);
    logic [DW:0] r;
    case (f)
      4'h1:    r = {1'b0, x} + {1'b0, y};
      4'h2:    r = {(x < y), x - y};
      4'h3:    r = {1'b0, x & y};
      4'h4:    r = {1'b0, x | y};
      4'h5:    r = {1'b0, x ^ y};
      4'h6:    r = {x[DW-1], x << 1};
      4'h7:    r = {x[0], x >> 1};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_res = alu(op, a_q, b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      rf_q    <= rf_d;
    end
  end

  // Operand latches carry no control meaning and are always reloaded in DECODE.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    rf_d    = rf_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_rdy) begin
          ir_d    = bus.D_in[15:0];
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            rf_d[rd] = alu_res[DW-1:0];
            n_d      = alu_res[DW-1];
            z_d      = (alu_res[DW-1:0] == '0);
            c_d      = alu_res[DW];
          end
          OP_LDI: rf_d[rd] = {{(DW-9){ir_q[8]}}, ir_q[8:0]};
          OP_LD, OP_ST: state_d = S_MEM;
          OP_JMP: pc_d = a_q[AW-1:0];
          OP_BZ:  if (z_q) pc_d = pc_q + {{(AW-9){ir_q[8]}}, ir_q[8:0]};
          OP_BN:  if (n_q) pc_d = pc_q + {{(AW-9){ir_q[8]}}, ir_q[8:0]};
          OP_BC:  if (c_q) pc_d = pc_q + {{(AW-9){ir_q[8]}}, ir_q[8:0]};
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        if (bus.mem_rdy) begin
          if (op == OP_LD) rf_d[rd] = bus.D_in;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Bus outputs depend only on state; reset overrides everything to idle.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mw_en   = 1'b0;
    bus.Address = pc_q;
    bus.D_out   = '0;
    halted_int  = 1'b0;
    case (state_q)
      S_FETCH: bus.mem_req = 1'b1;
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.Address = a_q[AW-1:0];
        if (op == OP_ST) begin
          bus.mw_en = 1'b1;
          bus.D_out = b_q;
        end
      end
      S_HALT:  halted_int = 1'b1;
      default: ;
    endcase
    status = {state_q, n_q, z_q, c_q, halted_int, bus.mem_req & ~bus.mem_rdy};
    halted = halted_int;
    if (reset) begin
      bus.mem_req = 1'b0;
      bus.mw_en   = 1'b0;
      bus.Address = '0;
      bus.D_out   = '0;
      status      = '0;
      halted      = 1'b0;
    end
  end

endmodule

// File: tb/tb_risc_core_mc.sv
// Bench for risc_core_mc: program ROM + data RAM model, store scoreboard,
// cycle-exact checks around reset, wait states, branches and HALT.
module tb_risc_core_mc;
  localparam int            DW  = 16;
  localparam int            AW  = 16;
  localparam logic [AW-1:0] RPC = 16'h0010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rdy = 1'b1;
  logic       stall_st = 1'b0;
  logic [7:0] status;
  logic       halted;

  logic [15:0] prog [0:127];
  logic [15:0] dmem [0:127];

  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int loop_fetch = 0;
  bit sb_en = 1'b1;

  always #5 clk = ~clk;

  risc_core_mc_if #(.DW(DW), .AW(AW)) bus ();

  // Addresses with bit 7 set hit data RAM, the rest hit program ROM.
  assign bus.D_in    = bus.Address[7] ? dmem[bus.Address[6:0]] : prog[bus.Address[6:0]];
  assign bus.mem_rdy = rdy & ~(stall_st & bus.mw_en);

  risc_core_mc #(.DW(DW), .AW(AW), .RESET_PC(RPC)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .status (status),
    .halted (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] r3(input int op, input int rd, input int rs, input int rt);
    return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] ri(input int op, input int rd, input int imm);
    return {op[3:0], rd[2:0], imm[8:0]};
  endfunction

  // Observe the bus mid-cycle: a write completes on the edge that follows.
  task automatic monitor();
    wr_t e;
    if (bus.mem_req && bus.mem_rdy && bus.mw_en) begin
      dmem[bus.Address[6:0]] = bus.D_out;
      wr_cnt++;
      if (sb_en) begin
        chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.Address), 32'(e.a));
          chk("wr_data", 32'(bus.D_out), 32'(e.d));
        end
      end
    end
    if (sb_en && bus.mem_req && bus.mem_rdy && status[7:5] == 3'd0 && bus.Address == 16'h0020)
      loop_fetch++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int n;
    int w0;
    for (int i = 0; i < 128; i++) begin
      prog[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
    prog[7'h10] = ri(8, 1, 5);        push_wr(16'h0000, 16'h0000); exp_q.pop_back();
    prog[7'h11] = ri(8, 2, -3);
    prog[7'h12] = r3(1, 3, 1, 2);     // 5 + -3 = 2, carry out
    prog[7'h13] = ri(8, 4, 'h80);
    prog[7'h14] = r3(10, 0, 4, 1);    push_wr(16'h0080, 16'h0005);
    prog[7'h15] = r3(9, 5, 4, 0);
    prog[7'h16] = ri(8, 6, 'h81);
    prog[7'h17] = r3(10, 0, 6, 5);    push_wr(16'h0081, 16'h0005);
    prog[7'h18] = ri(8, 6, 'h82);
    prog[7'h19] = r3(10, 0, 6, 3);    push_wr(16'h0082, 16'h0002);
    prog[7'h1A] = r3(2, 0, 1, 1);     // Z=1, N=0
    prog[7'h1B] = ri(13, 0, 1);       // BN not taken
    prog[7'h1C] = ri(12, 0, 1);       // BZ taken, skips 0x1D
    prog[7'h1D] = r3(10, 0, 6, 1);
    prog[7'h1E] = ri(8, 2, -1);
    prog[7'h1F] = ri(8, 7, -1);
    prog[7'h20] = r3(2, 7, 7, 2);     // R7 counts -1 -> 0 -> 1
    prog[7'h21] = ri(12, 0, -2);      // loop back once while Z
    prog[7'h22] = ri(8, 6, 'h83);
    prog[7'h23] = r3(10, 0, 6, 7);    push_wr(16'h0083, 16'h0001);
    prog[7'h24] = ri(8, 1, -256);     // 0xFF00
    prog[7'h25] = r3(6, 1, 1, 0);     // 0xFE00, C=1
    prog[7'h26] = ri(14, 0, 1);       // BC taken, skips 0x27
    prog[7'h27] = r3(10, 0, 6, 6);
    prog[7'h28] = r3(7, 3, 1, 0);     // 0x7F00
    prog[7'h29] = ri(8, 6, 'h84);
    prog[7'h2A] = r3(10, 0, 6, 3);    push_wr(16'h0084, 16'h7F00);
    prog[7'h2B] = r3(4, 3, 3, 5);     // 0x7F05
    prog[7'h2C] = r3(10, 0, 6, 3);    push_wr(16'h0084, 16'h7F05);
    prog[7'h2D] = ri(8, 7, 'h30);
    prog[7'h2E] = r3(11, 0, 7, 0);    // JMP skips 0x2F
    prog[7'h2F] = r3(10, 0, 6, 6);
    prog[7'h30] = r3(15, 0, 0, 0);

    // Reset state
    @(posedge clk); #1;
    step();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mw_en", 32'(bus.mw_en), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    reset = 1'b0;
    #1;
    chk("first_addr", 32'(bus.Address), 32'(RPC));
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_mw_en", 32'(bus.mw_en), 32'd0);
    chk("first_state", 32'(status[7:5]), 32'd0);

    // Three 3-cycle instructions: the ADD retires on the 9th edge
    repeat (8) step();
    chk("add_exec_state", 32'(status[7:5]), 32'd2);
    chk("flags_before_add", 32'(status[4:2]), 32'd0);
    step();
    chk("add_done_status", 32'(status), 32'h04);

    n = 0;
    while (!halted && n < 600) begin
      step();
      n++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    chk("halt_status", 32'(status), 32'hE2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_mem_req", 32'(bus.mem_req), 32'd0);
    end
    chk("halt_still", 32'(halted), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("loop_refetch", 32'(loop_fetch), 32'd2);
    chk("wr_count", 32'(wr_cnt), 32'd6);

    // Fetch wait states
    sb_en = 1'b0;
    reset = 1'b1;
    rdy   = 1'b0;
    step();
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_status", 32'(status), 32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("wait_addr", 32'(bus.Address), 32'(RPC));
      chk("wait_req", 32'(bus.mem_req), 32'd1);
      chk("wait_flag", 32'(status[0]), 32'd1);
      step();
    end
    rdy = 1'b1;
    #1;
    chk("wait_release", 32'(status), 32'd0);
    step();
    chk("pc_inc_once", 32'(bus.Address), 32'(RPC + 16'd1));
    chk("decode_state", 32'(status[7:5]), 32'd1);

    // Reset while a store waits for the memory
    stall_st = 1'b1;
    w0 = wr_cnt;
    n = 0;
    while (!bus.mw_en && n < 100) begin
      step();
      n++;
    end
    chk("st_seen", 32'(bus.mw_en), 32'd1);
    chk("st_addr", 32'(bus.Address), 32'h80);
    chk("st_data", 32'(bus.D_out), 32'h5);
    repeat (2) step();
    chk("st_hold_addr", 32'(bus.Address), 32'h80);
    chk("st_hold_mw_en", 32'(bus.mw_en), 32'd1);
    chk("st_hold_wait", 32'(status[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_mw_en", 32'(bus.mw_en), 32'd0);
    step();
    reset    = 1'b0;
    stall_st = 1'b0;
    #1;
    chk("rst_mid_pc", 32'(bus.Address), 32'(RPC));
    chk("rst_mid_mw_en_after", 32'(bus.mw_en), 32'd0);
    chk("rst_mid_state", 32'(status[7:5]), 32'd0);
    chk("rst_mid_no_write", 32'(wr_cnt), 32'(w0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
